// File: rtl/rgbw_fade_sequencer.sv
// rgbw_fade_sequencer
//
// Purpose:
//   Fades the four colour channel set-points (red/green/blue/white) from
//   their present values towards new targets. The block sits between the SPI
//   data dispenser and the colour generator. Each load strobe starts a ramp
//   that moves every channel by at most step_size per step. A step happens
//   once every step_div+1 clocks. A colour change therefore fades instead of
//   jumping.
//
// Ports:
//   clk        - system clock, sole clock of the block
//   reset      - synchronous, active-high reset
//   load       - 1-cycle strobe: capture tgt_*, step_div and step_size
//   tgt_red    - red target       (CH_W)
//   tgt_green  - green target     (CH_W)
//   tgt_blue   - blue target      (CH_W)
//   tgt_white  - white target     (CH_W)
//   step_div   - clocks per step minus 1 (0 = step every clock)
//   step_size  - max change per channel per step (0 behaves as 1)
//   hold       - freezes an active ramp (prescaler and outputs)
//   red_o      - current red value
//   green_o    - current green value
//   blue_o     - current blue value
//   white_o    - current white value
//   busy       - high while a ramp is in progress
//   done       - 1-cycle pulse when a ramp completes

module rgbw_fade_sequencer #(
    parameter int CH_W    = 16,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [CH_W-1:0]    tgt_red,
    input  logic [CH_W-1:0]    tgt_green,
    input  logic [CH_W-1:0]    tgt_blue,
    input  logic [CH_W-1:0]    tgt_white,
    input  logic [PRESC_W-1:0] step_div,
    input  logic [CH_W-1:0]    step_size,
    input  logic               hold,
    output logic [CH_W-1:0]    red_o,
    output logic [CH_W-1:0]    green_o,
    output logic [CH_W-1:0]    blue_o,
    output logic [CH_W-1:0]    white_o,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    localparam logic [CH_W-1:0] STEP_ONE = {{(CH_W-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             state_next;
    logic               done_next;

    logic [CH_W-1:0]    tgt_red_q;
    logic [CH_W-1:0]    tgt_green_q;
    logic [CH_W-1:0]    tgt_blue_q;
    logic [CH_W-1:0]    tgt_white_q;
    logic [PRESC_W-1:0] div_q;
    logic [CH_W-1:0]    step_q;
    logic [PRESC_W-1:0] presc_q;

    logic               ramp_run;
    logic               tick;
    logic               all_eq;

    // Move one channel towards its target by at most one step. The
    // difference is taken one bit wider than the channel and treated as
    // signed, so the direction is always known. When the remaining distance
    // fits inside one step, the channel lands exactly on the target. Because
    // of that, cur +/- step is only used when it stays inside the target
    // range, and the value never wraps.
    function automatic logic [CH_W-1:0] step_toward(
        input logic [CH_W-1:0] cur,
        input logic [CH_W-1:0] tgt,
        input logic [CH_W-1:0] step
    );
        logic signed [CH_W:0] d;
        logic        [CH_W:0] mag;
        d   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag = d[CH_W] ? $unsigned(-d) : $unsigned(d);
        if (mag <= {1'b0, step}) begin
            step_toward = tgt;
        end else if (d[CH_W]) begin
            step_toward = cur - step;
        end else begin
            step_toward = cur + step;
        end
    endfunction

    // A ramp only advances when it is active, not frozen, and not being
    // retargeted in this same cycle. A load always wins over stepping.
    assign ramp_run = (state == RAMP) && !hold && !load;
    assign tick     = ramp_run && (presc_q == div_q);

    assign all_eq = (red_o   == tgt_red_q)   &&
                    (green_o == tgt_green_q) &&
                    (blue_o  == tgt_blue_q)  &&
                    (white_o == tgt_white_q);

    assign busy = (state == RAMP);

    // State and done pulse registers. done is registered so that it appears
    // the cycle after the completion compare, together with the drop of busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    // Next-state logic. A load restarts the ramp from any state and masks any
    // completion seen in the same cycle. A ramp finishes once every channel
    // sits on its target. This is checked every RAMP cycle, not only on ticks,
    // so a load whose targets match the present colour still ends with done.
    // A held ramp never completes.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        if (load) begin
            state_next = RAMP;
        end else if ((state == RAMP) && !hold && all_eq) begin
            state_next = IDLE;
            done_next  = 1'b1;
        end
    end

    // Datapath: latched ramp parameters, step prescaler and channel values.
    // The channel outputs are never touched by a load. A retarget in the
    // middle of a ramp continues smoothly from wherever the colour is now.
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_red_q   <= '0;
            tgt_green_q <= '0;
            tgt_blue_q  <= '0;
            tgt_white_q <= '0;
            div_q       <= '0;
            step_q      <= STEP_ONE;
            presc_q     <= '0;
            red_o       <= '0;
            green_o     <= '0;
            blue_o      <= '0;
            white_o     <= '0;
        end else if (load) begin
            tgt_red_q   <= tgt_red;
            tgt_green_q <= tgt_green;
            tgt_blue_q  <= tgt_blue;
            tgt_white_q <= tgt_white;
            div_q       <= step_div;
            step_q      <= (step_size == '0) ? STEP_ONE : step_size;
            presc_q     <= '0;
        end else if (ramp_run) begin
            if (tick) begin
                presc_q <= '0;
                red_o   <= step_toward(red_o,   tgt_red_q,   step_q);
                green_o <= step_toward(green_o, tgt_green_q, step_q);
                blue_o  <= step_toward(blue_o,  tgt_blue_q,  step_q);
                white_o <= step_toward(white_o, tgt_white_q, step_q);
            end else begin
                presc_q <= presc_q + PRESC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rgbw_fade_sequencer.sv
// tb_rgbw_fade_sequencer
//
// Purpose:
//   Self-checking bench for rgbw_fade_sequencer. It uses directed loads with
//   hand-computed expected channel values and busy/done timing. The bench
//   covers plain ramps, a slow prescaled ramp, retarget mid-ramp, clamping
//   at both ends of the range, a zero step size, hold, and reset mid-ramp.
//
// Ports: none (top-level bench).

module tb_rgbw_fade_sequencer;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] tgt_red;
    logic [15:0] tgt_green;
    logic [15:0] tgt_blue;
    logic [15:0] tgt_white;
    logic [15:0] step_div;
    logic [15:0] step_size;
    logic        hold;
    logic [15:0] red_o;
    logic [15:0] green_o;
    logic [15:0] blue_o;
    logic [15:0] white_o;
    logic        busy;
    logic        done;

    int compare_count  = 0;
    int mismatch_count = 0;

    rgbw_fade_sequencer #(
        .CH_W    (16),
        .PRESC_W (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .tgt_red   (tgt_red),
        .tgt_green (tgt_green),
        .tgt_blue  (tgt_blue),
        .tgt_white (tgt_white),
        .step_div  (step_div),
        .step_size (step_size),
        .hold      (hold),
        .red_o     (red_o),
        .green_o   (green_o),
        .blue_o    (blue_o),
        .white_o   (white_o),
        .busy      (busy),
        .done      (done)
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step one clock. Outputs are sampled and inputs driven 1 ns after the
    // rising edge, well away from the active edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value with its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Red channel plus handshake flags, the most common check in this bench.
    task automatic checkRed(input string tag, input logic [15:0] exp_red,
                            input logic exp_busy, input logic exp_done);
        checkOutput({tag, " red"},  {16'h0, red_o}, {16'h0, exp_red});
        checkOutput({tag, " busy"}, {31'h0, busy},  {31'h0, exp_busy});
        checkOutput({tag, " done"}, {31'h0, done},  {31'h0, exp_done});
    endtask

    // Present a one-cycle load. On return the load edge has passed, so the
    // bench stands in the first RAMP cycle.
    task automatic applyStimulus(input logic [15:0] r, input logic [15:0] g,
                                 input logic [15:0] b, input logic [15:0] w,
                                 input logic [15:0] div, input logic [15:0] step);
        tgt_red   = r;
        tgt_green = g;
        tgt_blue  = b;
        tgt_white = w;
        step_div  = div;
        step_size = step;
        load      = 1'b1;
        cycle();
        load      = 1'b0;
    endtask

    task automatic resetPulse();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        tgt_red   = '0;
        tgt_green = '0;
        tgt_blue  = '0;
        tgt_white = '0;
        step_div  = '0;
        step_size = '0;
        hold      = 1'b0;
        cycle();
        cycle();

        // Reset state.
        checkOutput("rst red",   {16'h0, red_o},   32'h0);
        checkOutput("rst green", {16'h0, green_o}, 32'h0);
        checkOutput("rst blue",  {16'h0, blue_o},  32'h0);
        checkOutput("rst white", {16'h0, white_o}, 32'h0);
        checkOutput("rst busy",  {31'h0, busy},    32'h0);
        checkOutput("rst done",  {31'h0, done},    32'h0);
        reset = 1'b0;
        cycle();

        // Red 0 -> 0x10 in steps of 4, one step per clock.
        applyStimulus(16'h0010, 16'h0, 16'h0, 16'h0, 16'd0, 16'd4);
        checkRed("t1 entry", 16'h0000, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cycle();
            checkRed($sformatf("t1 step%0d", i), 16'(4 * i), 1'b1, 1'b0);
        end
        cycle();
        checkRed("t1 done", 16'h0010, 1'b0, 1'b1);
        cycle();
        checkRed("t1 after", 16'h0010, 1'b0, 1'b0);

        // White 0 -> 0x300, step 0x100 every 4 clocks. Red stays at its target.
        applyStimulus(16'h0010, 16'h0, 16'h0, 16'h0300, 16'd3, 16'h0100);
        for (int k = 1; k <= 3; k++) begin
            repeat (3) cycle();
            checkOutput($sformatf("t2 hold%0d white", k), {16'h0, white_o},
                        32'((k - 1) * 32'h100));
            cycle();
            checkOutput($sformatf("t2 step%0d white", k), {16'h0, white_o},
                        32'(k * 32'h100));
        end
        checkOutput("t2 last done", {31'h0, done}, 32'h0);
        cycle();
        checkOutput("t2 done", {31'h0, done}, 32'h1);
        checkOutput("t2 busy", {31'h0, busy}, 32'h0);

        // Retarget mid-ramp: red climbs towards 0xFFFF, then at 0x3000 it is
        // sent back to 0 and must descend from there with a single done.
        resetPulse();
        applyStimulus(16'hFFFF, 16'h0, 16'h0, 16'h0, 16'd0, 16'h1000);
        for (int i = 1; i <= 3; i++) begin
            cycle();
            checkRed($sformatf("t3 up%0d", i), 16'(i * 32'h1000), 1'b1, 1'b0);
        end
        applyStimulus(16'h0000, 16'h0, 16'h0, 16'h0, 16'd0, 16'h1000);
        checkRed("t3 retarget", 16'h3000, 1'b1, 1'b0);
        for (int i = 2; i >= 0; i--) begin
            cycle();
            checkRed($sformatf("t3 down%0d", i), 16'(i * 32'h1000), 1'b1, 1'b0);
        end
        cycle();
        checkRed("t3 done", 16'h0000, 1'b0, 1'b1);
        cycle();
        checkRed("t3 after", 16'h0000, 1'b0, 1'b0);

        // Clamping at the top and bottom of the range.
        applyStimulus(16'hF000, 16'h0, 16'h0, 16'h0, 16'd0, 16'hF000);
        cycle();
        checkRed("t4 f000", 16'hF000, 1'b1, 1'b0);
        cycle();
        applyStimulus(16'hFFFF, 16'h0, 16'h0, 16'h0, 16'd0, 16'h8000);
        cycle();
        checkRed("t4 clamp top", 16'hFFFF, 1'b1, 1'b0);
        cycle();
        checkRed("t4 top done", 16'hFFFF, 1'b0, 1'b1);
        applyStimulus(16'h0000, 16'h0, 16'h0, 16'h0, 16'd0, 16'hC000);
        cycle();
        checkRed("t4 down", 16'h3FFF, 1'b1, 1'b0);
        cycle();
        checkRed("t4 clamp bottom", 16'h0000, 1'b1, 1'b0);
        cycle();
        checkRed("t4 bottom done", 16'h0000, 1'b0, 1'b1);

        // Step size 0 behaves as 1; red and green ramp together.
        applyStimulus(16'h0003, 16'h0002, 16'h0, 16'h0, 16'd0, 16'd0);
        for (int i = 1; i <= 3; i++) begin
            cycle();
            checkRed($sformatf("t4 unit%0d", i), 16'(i), 1'b1, 1'b0);
            checkOutput($sformatf("t4 unit%0d green", i), {16'h0, green_o},
                        32'((i > 2) ? 2 : i));
        end
        cycle();
        checkRed("t4 unit done", 16'h0003, 1'b0, 1'b1);

        // A load whose targets equal the current colour completes immediately.
        applyStimulus(16'h0003, 16'h0002, 16'h0, 16'h0, 16'd0, 16'd1);
        checkRed("t4 same entry", 16'h0003, 1'b1, 1'b0);
        cycle();
        checkRed("t4 same done", 16'h0003, 1'b0, 1'b1);

        // Hold mid-ramp: with div=2 a leaking prescaler would change the
        // phase of the next step after 10 held clocks.
        applyStimulus(16'h0009, 16'h0002, 16'h0, 16'h0, 16'd2, 16'd2);
        repeat (3) cycle();
        checkRed("t5 first step", 16'h0005, 1'b1, 1'b0);
        cycle();
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checkRed($sformatf("t5 held%0d", i), 16'h0005, 1'b1, 1'b0);
        end
        hold = 1'b0;
        cycle();
        checkRed("t5 resume phase", 16'h0005, 1'b1, 1'b0);
        cycle();
        checkRed("t5 resume step", 16'h0007, 1'b1, 1'b0);
        hold = 1'b1;
        applyStimulus(16'h0010, 16'h0002, 16'h0, 16'h0, 16'd0, 16'h0010);
        checkRed("t5 load in hold", 16'h0007, 1'b1, 1'b0);
        cycle();
        checkRed("t5 held after load", 16'h0007, 1'b1, 1'b0);
        hold = 1'b0;
        cycle();
        checkRed("t5 released", 16'h0010, 1'b1, 1'b0);
        cycle();
        checkRed("t5 done", 16'h0010, 1'b0, 1'b1);

        // Reset mid-ramp, then a load of all-zero targets.
        applyStimulus(16'h0100, 16'h0200, 16'h0, 16'h0, 16'd0, 16'd1);
        cycle();
        cycle();
        checkOutput("t6 pre-reset green", {16'h0, green_o}, 32'h0004);
        resetPulse();
        checkRed("t6 reset", 16'h0000, 1'b0, 1'b0);
        checkOutput("t6 reset green", {16'h0, green_o}, 32'h0);
        cycle();
        checkRed("t6 post reset", 16'h0000, 1'b0, 1'b0);
        applyStimulus(16'h0, 16'h0, 16'h0, 16'h0, 16'd0, 16'd0);
        checkRed("t6 zero entry", 16'h0000, 1'b1, 1'b0);
        cycle();
        checkRed("t6 zero done", 16'h0000, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
